// File: rtl/pipe_hazard_ctrl.sv
// Hazard and pipeline-sequencing controller for the 5-stage pipeline:
// data-hazard stalls, redirect flush, multi-cycle MDU hold, interrupt drain/take and exceptions.
module pipe_hazard_ctrl #(
  parameter int unsigned RA_W      = 5,
  parameter int unsigned MDU_LAT   = 8,
  parameter bit          FWD_EN    = 1'b1,
  parameter int unsigned DRAIN_CYC = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic            id_use_rs,
  input  logic            id_use_rt,
  input  logic            id_early,
  input  logic            id_redirect,
  input  logic            ex_wr,
  input  logic            ex_load,
  input  logic [RA_W-1:0] ex_wa,
  input  logic            mem_wr,
  input  logic            mem_load,
  input  logic [RA_W-1:0] mem_wa,
  input  logic            mdu_start,
  input  logic            irq,
  input  logic            exc,
  output logic            stall_pc,
  output logic            stall_ifid,
  output logic            bubble_idex,
  output logic            hold_ex,
  output logic            flush_ifid,
  output logic            flush_front,
  output logic            take_irq,
  output logic            take_exc,
  output logic            mdu_busy,
  output logic [1:0]      state_o
);

  localparam int unsigned MC_W = $clog2(MDU_LAT + 1);
  localparam int unsigned DC_W = $clog2(DRAIN_CYC + 1);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_MDU   = 2'd1,
    S_DRAIN = 2'd2,
    S_TAKE  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [MC_W-1:0] mdu_cnt_q, mdu_cnt_d;
  logic [DC_W-1:0] drain_cnt_q, drain_cnt_d;
  logic            irq_pend_q, irq_pend_d;
  logic            exc_pend_q, exc_pend_d;
  logic            take_exc_q, take_exc_d;

  logic m_ex, m_mem, data_stall;

  // Register 0 is hardwired, so a write to it never creates a dependency.
  always_comb begin
    m_ex  = (ex_wa != '0) &&
            ((id_use_rs && (id_rs == ex_wa)) || (id_use_rt && (id_rt == ex_wa)));
    m_mem = (mem_wa != '0) &&
            ((id_use_rs && (id_rs == mem_wa)) || (id_use_rt && (id_rt == mem_wa)));
    data_stall = (ex_wr && m_ex && (ex_load || id_early)) ||
                 (id_early && mem_load && mem_wr && m_mem) ||
                 (!FWD_EN && ((ex_wr && m_ex) || (mem_wr && m_mem)));
  end

  always_comb begin
    state_d     = state_q;
    mdu_cnt_d   = mdu_cnt_q;
    drain_cnt_d = drain_cnt_q;
    irq_pend_d  = irq_pend_q;
    exc_pend_d  = exc_pend_q;
    take_exc_d  = take_exc_q;
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    bubble_idex = 1'b0;
    hold_ex     = 1'b0;
    flush_ifid  = 1'b0;
    flush_front = 1'b0;
    take_irq    = 1'b0;
    take_exc    = 1'b0;
    mdu_busy    = 1'b0;
    state_o     = state_q;

    case (state_q)
      S_RUN: begin
        stall_pc    = data_stall;
        stall_ifid  = data_stall;
        bubble_idex = data_stall;
        // A stalled redirect stays in ID, so it is naturally retried once the stall clears.
        flush_ifid  = id_redirect && !data_stall;
        if (irq) irq_pend_d = 1'b1;
        if (exc) begin
          state_d    = S_TAKE;
          take_exc_d = 1'b1;
        end else if (mdu_start) begin
          state_d   = S_MDU;
          mdu_cnt_d = MC_W'(MDU_LAT - 1);
        end else if (irq_pend_q) begin
          state_d     = S_DRAIN;
          drain_cnt_d = DC_W'(DRAIN_CYC);
        end
      end
      S_MDU: begin
        hold_ex    = 1'b1;
        stall_pc   = 1'b1;
        stall_ifid = 1'b1;
        mdu_busy   = 1'b1;
        mdu_cnt_d  = mdu_cnt_q - MC_W'(1);
        if (irq) irq_pend_d = 1'b1;
        if (exc) exc_pend_d = 1'b1;
        if (mdu_cnt_q == MC_W'(1)) begin
          if (exc_pend_q || exc) begin
            state_d    = S_TAKE;
            take_exc_d = 1'b1;
            exc_pend_d = 1'b0;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_DRAIN: begin
        stall_pc    = 1'b1;
        stall_ifid  = 1'b1;
        bubble_idex = 1'b1;
        drain_cnt_d = drain_cnt_q - DC_W'(1);
        if (exc) begin
          state_d    = S_TAKE;
          take_exc_d = 1'b1;
        end else if (drain_cnt_q == DC_W'(1)) begin
          state_d    = S_TAKE;
          take_exc_d = 1'b0;
        end
      end
      S_TAKE: begin
        flush_front = 1'b1;
        take_exc    = take_exc_q;
        take_irq    = !take_exc_q;
        // An exception take leaves a pending interrupt for service after return.
        if (!take_exc_q) irq_pend_d = 1'b0;
        state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase

    if (reset) begin
      stall_pc    = 1'b0;
      stall_ifid  = 1'b0;
      bubble_idex = 1'b0;
      hold_ex     = 1'b0;
      flush_ifid  = 1'b0;
      flush_front = 1'b0;
      take_irq    = 1'b0;
      take_exc    = 1'b0;
      mdu_busy    = 1'b0;
      state_o     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_RUN;
      mdu_cnt_q   <= '0;
      drain_cnt_q <= '0;
      irq_pend_q  <= 1'b0;
      exc_pend_q  <= 1'b0;
      take_exc_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mdu_cnt_q   <= mdu_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      irq_pend_q  <= irq_pend_d;
      exc_pend_q  <= exc_pend_d;
      take_exc_q  <= take_exc_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a forwarding instance and a no-forwarding instance
// share the same stimulus; directed vectors push expected outputs, a monitor compares per cycle.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_wa, mem_wa;
  logic       id_use_rs, id_use_rt, id_early, id_redirect;
  logic       ex_wr, ex_load, mem_wr, mem_load, mdu_start, irq, exc;

  logic       stall_pc, stall_ifid, bubble_idex, hold_ex, flush_ifid, flush_front;
  logic       take_irq, take_exc, mdu_busy;
  logic [1:0] state_o;

  logic       n_stall_pc, n_stall_ifid, n_bubble_idex, n_hold_ex, n_flush_ifid, n_flush_front;
  logic       n_take_irq, n_take_exc, n_mdu_busy;
  logic [1:0] n_state_o;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.RA_W(5), .MDU_LAT(8), .FWD_EN(1'b1), .DRAIN_CYC(2)) u_dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_early(id_early),
    .id_redirect(id_redirect), .ex_wr(ex_wr), .ex_load(ex_load), .ex_wa(ex_wa),
    .mem_wr(mem_wr), .mem_load(mem_load), .mem_wa(mem_wa), .mdu_start(mdu_start),
    .irq(irq), .exc(exc), .stall_pc(stall_pc), .stall_ifid(stall_ifid),
    .bubble_idex(bubble_idex), .hold_ex(hold_ex), .flush_ifid(flush_ifid),
    .flush_front(flush_front), .take_irq(take_irq), .take_exc(take_exc),
    .mdu_busy(mdu_busy), .state_o(state_o)
  );

  pipe_hazard_ctrl #(.RA_W(5), .MDU_LAT(8), .FWD_EN(1'b0), .DRAIN_CYC(2)) u_dut_nf (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_early(id_early),
    .id_redirect(id_redirect), .ex_wr(ex_wr), .ex_load(ex_load), .ex_wa(ex_wa),
    .mem_wr(mem_wr), .mem_load(mem_load), .mem_wa(mem_wa), .mdu_start(mdu_start),
    .irq(irq), .exc(exc), .stall_pc(n_stall_pc), .stall_ifid(n_stall_ifid),
    .bubble_idex(n_bubble_idex), .hold_ex(n_hold_ex), .flush_ifid(n_flush_ifid),
    .flush_front(n_flush_front), .take_irq(n_take_irq), .take_exc(n_take_exc),
    .mdu_busy(n_mdu_busy), .state_o(n_state_o)
  );

  // {state, stall_pc, stall_ifid, bubble, hold_ex, mdu_busy, flush_ifid, flush_front,
  //  take_irq, take_exc, nofwd stall_pc, nofwd flush_ifid}
  typedef logic [12:0] vec_t;
  typedef struct {
    string nm;
    vec_t  v;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  localparam vec_t Z = '0;

  function automatic vec_t ex(logic [1:0] st, logic s, logic b, logic h, logic f,
                              logic ff, logic ti, logic te, logic ns, logic nf);
    return {st, s, s, b, h, h, f, ff, ti, te, ns, nf};
  endfunction

  function automatic vec_t act();
    return {state_o, stall_pc, stall_ifid, bubble_idex, hold_ex, mdu_busy, flush_ifid,
            flush_front, take_irq, take_exc, n_stall_pc, n_flush_ifid};
  endfunction

  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      exp_t e;
      vec_t a;
      e = sb_q.pop_front();
      a = act();
      n_chk++;
      if (a !== e.v) begin
        n_fail++;
        $display("FAIL %s: actual=%b required=%b", e.nm, a, e.v);
      end
    end
  end

  task automatic clr();
    id_rs = '0; id_rt = '0; ex_wa = '0; mem_wa = '0;
    id_use_rs = 0; id_use_rt = 0; id_early = 0; id_redirect = 0;
    ex_wr = 0; ex_load = 0; mem_wr = 0; mem_load = 0; mdu_start = 0; irq = 0; exc = 0;
  endtask

  task automatic cyc(string nm, vec_t e);
    exp_t x;
    x.nm = nm;
    x.v  = e;
    sb_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic load_in_ex(logic [4:0] wa);
    ex_load = 1; ex_wr = 1; ex_wa = wa;
  endtask

  initial begin
    reset = 1'b1;
    clr();
    @(posedge clk);
    #1;
    // Reset with active hazards and requests: everything must read 0.
    load_in_ex(5'd8); id_rs = 5'd8; id_use_rs = 1; irq = 1; mdu_start = 1;
    cyc("rst_a", Z);
    cyc("rst_b", Z);
    reset = 1'b0;
    clr();
    cyc("idle", Z);

    // Load-use
    load_in_ex(5'd8); id_rs = 5'd8; id_use_rs = 1;
    cyc("lu_ex", ex(0, 1, 1, 0, 0, 0, 0, 0, 1, 0));
    clr(); mem_load = 1; mem_wr = 1; mem_wa = 5'd8; id_rs = 5'd8; id_use_rs = 1;
    cyc("lu_mem", ex(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    clr(); load_in_ex(5'd0); id_rs = 5'd0; id_use_rs = 1;
    cyc("lu_r0", Z);
    clr(); load_in_ex(5'd8); id_rs = 5'd8; id_rt = 5'd8; id_use_rt = 1;
    cyc("lu_rt", ex(0, 1, 1, 0, 0, 0, 0, 0, 1, 0));
    clr(); load_in_ex(5'd8); id_rs = 5'd8;
    cyc("lu_nouse", Z);

    // Branch after ALU producer
    clr(); id_early = 1; id_rs = 5'd9; id_use_rs = 1; ex_wr = 1; ex_wa = 5'd9;
    cyc("br_alu_ex", ex(0, 1, 1, 0, 0, 0, 0, 0, 1, 0));
    clr(); id_early = 1; id_rs = 5'd9; id_use_rs = 1; mem_wr = 1; mem_wa = 5'd9;
    cyc("br_alu_mem", ex(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    clr(); id_early = 1; id_rs = 5'd9; id_use_rs = 1;
    cyc("br_alu_wb", Z);

    // Branch after load producer
    clr(); id_early = 1; id_rs = 5'd9; id_use_rs = 1; load_in_ex(5'd9);
    cyc("br_ld_ex", ex(0, 1, 1, 0, 0, 0, 0, 0, 1, 0));
    clr(); id_early = 1; id_rs = 5'd9; id_use_rs = 1; mem_load = 1; mem_wr = 1; mem_wa = 5'd9;
    cyc("br_ld_mem", ex(0, 1, 1, 0, 0, 0, 0, 0, 1, 0));
    clr(); id_early = 1; id_rs = 5'd9; id_use_rs = 1;
    cyc("br_ld_wb", Z);

    // Redirect under stall, then plain redirect
    clr(); id_redirect = 1; load_in_ex(5'd8); id_rs = 5'd8; id_use_rs = 1;
    cyc("redir_stall", ex(0, 1, 1, 0, 0, 0, 0, 0, 1, 0));
    clr(); id_redirect = 1; mem_load = 1; mem_wr = 1; mem_wa = 5'd8; id_rs = 5'd8; id_use_rs = 1;
    cyc("redir_go", ex(0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
    clr();
    cyc("redir_done", Z);
    id_redirect = 1;
    cyc("redir_plain", ex(0, 0, 0, 0, 1, 0, 0, 0, 0, 1));

    // MDU hold with an interrupt (and ignored hazard/redirect) mid-way
    clr(); mdu_start = 1;
    cyc("mdu_start", Z);
    for (int i = 0; i < 7; i++) begin
      clr();
      if (i == 2) begin
        irq = 1; id_redirect = 1; load_in_ex(5'd8); id_rs = 5'd8; id_use_rs = 1;
      end
      cyc($sformatf("mdu_hold%0d", i), ex(1, 1, 0, 1, 0, 0, 0, 0, 1, 0));
    end
    clr();
    cyc("mdu_ret", Z);
    cyc("mdu_drain0", ex(2, 1, 1, 0, 0, 0, 0, 0, 1, 0));
    cyc("mdu_drain1", ex(2, 1, 1, 0, 0, 0, 0, 0, 1, 0));
    cyc("mdu_take", ex(3, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    cyc("mdu_idle0", Z);
    cyc("mdu_idle1", Z);

    // Exception and interrupt in the same cycle
    exc = 1; irq = 1;
    cyc("ei_req", Z);
    clr();
    cyc("ei_take_exc", ex(3, 0, 0, 0, 0, 1, 0, 1, 0, 0));
    cyc("ei_run", Z);
    cyc("ei_drain0", ex(2, 1, 1, 0, 0, 0, 0, 0, 1, 0));
    cyc("ei_drain1", ex(2, 1, 1, 0, 0, 0, 0, 0, 1, 0));
    cyc("ei_take_irq", ex(3, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    cyc("ei_idle", Z);

    // Exception during MDU is taken at expiry
    mdu_start = 1;
    cyc("mx_start", Z);
    for (int i = 0; i < 7; i++) begin
      clr();
      if (i == 1) exc = 1;
      cyc($sformatf("mx_hold%0d", i), ex(1, 1, 0, 1, 0, 0, 0, 0, 1, 0));
    end
    clr();
    cyc("mx_take_exc", ex(3, 0, 0, 0, 0, 1, 0, 1, 0, 0));
    cyc("mx_idle0", Z);
    cyc("mx_idle1", Z);

    // Exception during DRAIN preempts; interrupt serviced afterwards
    irq = 1;
    cyc("xd_irq", Z);
    clr();
    cyc("xd_run", Z);
    exc = 1;
    cyc("xd_drain_exc", ex(2, 1, 1, 0, 0, 0, 0, 0, 1, 0));
    clr();
    cyc("xd_take_exc", ex(3, 0, 0, 0, 0, 1, 0, 1, 0, 0));
    cyc("xd_run2", Z);
    cyc("xd_drain0", ex(2, 1, 1, 0, 0, 0, 0, 0, 1, 0));
    cyc("xd_drain1", ex(2, 1, 1, 0, 0, 0, 0, 0, 1, 0));
    cyc("xd_take_irq", ex(3, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    cyc("xd_idle", Z);

    // Reset in the middle of DRAIN clears the pending interrupt
    irq = 1;
    cyc("rd_irq", Z);
    clr();
    cyc("rd_run", Z);
    cyc("rd_drain0", ex(2, 1, 1, 0, 0, 0, 0, 0, 1, 0));
    reset = 1'b1;
    cyc("rd_reset", Z);
    reset = 1'b0;
    cyc("rd_idle0", Z);
    cyc("rd_idle1", Z);
    cyc("rd_idle2", Z);

    for (int i = 0; i < 5 && sb_q.size() != 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_queue: actual=%0d pending required=0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised hazard and pipeline-sequencing controller for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB). It replaces the fixed load-use/branch stall-flush logic. It adds:
- configurable forwarding availability,
- multi-cycle multiply/divide (MDU) hold with a latency counter,
- an interrupt drain/take state machine with exception priority.

All stall, flush and hold controls for the pipeline registers come from this block.

Parameters:
- RA_W, 5, register address width.
- MDU_LAT, 8, total EX-occupancy cycles of a multi-cycle op (≥2).
- FWD_EN, 1, 1 = EX-ALU and MEM-ALU results are forwardable; 0 = no forwarding.
- DRAIN_CYC, 2, cycles allowed for MEM/WB to retire before an interrupt is taken (≥1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- id_rs, id_rt  in  RA_W each  source registers of the ID instruction
- id_use_rs, id_use_rt  in  1 each  ID instruction reads rs / rt
- id_early  in  1  ID instruction consumes its operands in ID (branch, jr)
- id_redirect  in  1  ID resolved a taken branch/jump/jr
- ex_wr, ex_load  in  1 each  EX instruction writes a register / is a load
- ex_wa  in  RA_W  EX destination register
- mem_wr, mem_load  in  1 each  MEM instruction writes a register / is a load
- mem_wa  in  RA_W  MEM destination register
- mdu_start  in  1  EX holds a multi-cycle op this cycle
- irq  in  1  level interrupt request
- exc  in  1  synchronous exception raised in ID
- stall_pc, stall_ifid  out  1 each  hold PC / hold IF_ID
- bubble_idex  out  1  load NOP into ID_EX
- hold_ex  out  1  hold ID_EX and EX_MEM; insert bubble into MEM_WB
- flush_ifid  out  1  load NOP into IF_ID
- flush_front  out  1  NOP into IF_ID and ID_EX
- take_irq, take_exc  out  1 each  one-cycle select of the handler vector; EPC capture
- mdu_busy  out  1  MDU counter active
- state_o  out  2  current FSM state (debug)

Behaviour:
- FSM states: RUN=0, MDU=1, DRAIN=2, TAKE=3. Reset → RUN; MDU counter=0; irq_pend=0; drain counter=0.
- Reset mid-operation: any state aborts to RUN the next edge. All outputs are 0 while reset is high.
- Match definition: match(x,wa) = use_x && x==wa && wa!=0. Register 0 never causes a hazard.
- Data-hazard stall (RUN only; combinational, same cycle). Any term below asserts stall_pc, stall_ifid and bubble_idex:
  - ex_load & ex_wr & match(rs|rt, ex_wa).
  - id_early & ex_wr & match(rs|rt, ex_wa).
  - id_early & mem_load & mem_wr & match(rs|rt, mem_wa).
  - FWD_EN=0 only: (ex_wr|mem_wr) & match(rs|rt, respective wa).
- Redirect: flush_ifid=1 when id_redirect & no data stall, for exactly one cycle. If a stall is active, the redirect is deferred until the stall clears.
- MDU path:
  - RUN & mdu_start → MDU at the next edge; counter loads MDU_LAT-1.
  - In MDU: hold_ex=stall_pc=stall_ifid=mdu_busy=1 and the counter decrements.
  - Counter==1 → RUN at the next edge. The total hold is MDU_LAT-1 cycles after the start cycle.
  - Data-hazard terms are ignored while in MDU.
- Interrupt path:
  - irq sampled in RUN sets irq_pend; irq sampled in MDU sets irq_pend but remains in MDU.
  - RUN & irq_pend & no mdu_start → DRAIN.
  - DRAIN: stall_pc=stall_ifid=bubble_idex=1 for DRAIN_CYC cycles, then → TAKE.
  - TAKE (one cycle): take_irq=1, flush_front=1, irq_pend cleared → RUN.
- Exception path:
  - exc in RUN or DRAIN → TAKE at the next edge with take_exc=1 (take_irq=0). irq_pend is retained and serviced after return to RUN.
  - exc in MDU is latched and taken when the MDU counter expires.
- Priority: reset > exc > MDU hold > irq drain > data stall > redirect.
- When hold_ex or DRAIN is active, flush_ifid is suppressed.

Test Plan:
- Load-use hazard: ex_load=1, ex_wr=1, ex_wa=8, id_rs=8, id_use_rs=1 → stall_pc=stall_ifid=bubble_idex=1 for exactly 1 cycle. With ex_wa=0 the result is no stall.
- Branch after load: beq in ID (id_early=1) reading $9, ALU producer of $9 in EX. Expect a 1-cycle stall. If the producer is a load, expect a stall in EX then a second stall cycle in MEM, 2 total. With FWD_EN=0 an ALU producer also gives 2 cycles.
- MDU hold: mdu_start pulse with MDU_LAT=8 → hold_ex=mdu_busy=1 for 7 cycles, state_o=1, then state_o=0. An irq asserted mid-MDU is taken after return: DRAIN for 2 cycles, then take_irq for 1 cycle.
- Redirect under stall: id_redirect=1 coincident with a load-use stall → flush_ifid=0 that cycle and 1 the next cycle.
- Exception vs interrupt: exc=1 and irq=1 in the same RUN cycle → next cycle take_exc=1, take_irq=0. Then DRAIN for 2 cycles and take_irq=1.
- Reset mid-DRAIN: reset pulse in DRAIN → state_o=0, all outputs 0, irq_pend cleared.
